// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped BTB with 2-bit saturating counters,
// looked up combinationally at fetch and trained by the outcome resolved in execute.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PCF,
  output logic              PredTakenF,
  output logic [31:0]       PredTargetF,
  input  logic              UpdateE,
  input  logic              JumpE,
  input  logic [31:0]       PCE,
  input  logic              TakenE,
  input  logic [31:0]       TargetE,
  input  logic              PredTakenE,
  input  logic [31:0]       PredTargetE,
  output logic              MispredictE,
  output logic [31:0]       RecoverPCE,
  output logic [PERF_W-1:0] BranchCnt,
  output logic [PERF_W-1:0] MispredCnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic              validQ  [ENTRIES];
  logic [TAG_W-1:0]  tagQ    [ENTRIES];
  logic [31:0]       targetQ [ENTRIES];
  logic [1:0]        ctrQ    [ENTRIES];

  logic [IDX_BITS-1:0] idxF, idxE;
  logic [TAG_W-1:0]    tagF, tagE;
  logic                hitF, hitE;
  logic                unusedBits;

  function automatic logic [1:0] satInc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] satDec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Instructions are word aligned, so the two low PC bits never select anything.
  assign unusedBits = ^{PCF[1:0], PCE[1:0]};

  assign idxF = PCF[IDX_BITS+1:2];
  assign tagF = PCF[31:IDX_BITS+2];
  assign idxE = PCE[IDX_BITS+1:2];
  assign tagE = PCE[31:IDX_BITS+2];

  assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);
  assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

  assign PredTakenF  = hitF & ctrQ[idxF][1];
  assign PredTargetF = hitF ? targetQ[idxF] : PCF + 32'd4;

  assign MispredictE = UpdateE & ((TakenE != PredTakenE) |
                                  (TakenE & PredTakenE & (TargetE != PredTargetE)));
  assign RecoverPCE  = TakenE ? TargetE : PCE + 32'd4;

  // Table training; a not-taken miss leaves the table untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= '0;
        ctrQ[i]    <= 2'b01;
      end
    end else if (UpdateE) begin
      if (hitE) begin
        if (JumpE) begin
          ctrQ[idxE]    <= 2'b11;
          targetQ[idxE] <= TargetE;
        end else if (TakenE) begin
          ctrQ[idxE]    <= satInc(ctrQ[idxE]);
          targetQ[idxE] <= TargetE;
        end else begin
          ctrQ[idxE]    <= satDec(ctrQ[idxE]);
        end
      end else if (TakenE) begin
        validQ[idxE]  <= 1'b1;
        tagQ[idxE]    <= tagE;
        targetQ[idxE] <= TargetE;
        ctrQ[idxE]    <= JumpE ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      BranchCnt  <= BranchCnt + PERF_W'(UpdateE);
      MispredCnt <= MispredCnt + PERF_W'(MispredictE);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, reset corner case, and
// randomized traffic checked against an entry-level behavioural model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PCE, TargetE, PredTargetE, PredTargetF, RecoverPCE;
  logic        UpdateE, JumpE, TakenE, PredTakenE, PredTakenF, MispredictE;
  logic [31:0] BranchCnt, MispredCnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(4), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .UpdateE(UpdateE), .JumpE(JumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .RecoverPCE(RecoverPCE), .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  typedef struct {
    logic [31:0] pcf;
    logic        upd, jmp;
    logic [31:0] pce;
    logic        tkn;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptg;
    logic        eTk;
    logic [31:0] eTg;
    logic        eMis;
    logic [31:0] eRec;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic [31:0] pcf, logic upd, logic jmp, logic [31:0] pce,
                              logic tkn, logic [31:0] tgt, logic ptk, logic [31:0] ptg,
                              logic eTk, logic [31:0] eTg, logic eMis, logic [31:0] eRec);
    vec_t v;
    v.pcf = pcf; v.upd = upd; v.jmp = jmp; v.pce = pce; v.tkn = tkn; v.tgt = tgt;
    v.ptk = ptk; v.ptg = ptg; v.eTk = eTk; v.eTg = eTg; v.eMis = eMis; v.eRec = eRec;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    PCF = v.pcf; UpdateE = v.upd; JumpE = v.jmp; PCE = v.pce; TakenE = v.tkn;
    TargetE = v.tgt; PredTakenE = v.ptk; PredTargetE = v.ptg;
  endtask

  // Behavioural model: one record per table slot, counters as plain 0..3 integers.
  bit          mValid [16];
  int unsigned mTag   [16];
  logic [31:0] mTgt   [16];
  int          mCtr   [16];
  int unsigned mBr, mMis;

  function automatic int slotOf(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit mHit(logic [31:0] pc);
    return mValid[slotOf(pc)] && (mTag[slotOf(pc)] == pc / 64);
  endfunction

  function automatic bit mMisp(vec_t v);
    return v.upd && ((v.tkn != v.ptk) || (v.tkn && v.ptk && v.tgt != v.ptg));
  endfunction

  task automatic mReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mTag[i] = 0; mTgt[i] = 0; mCtr[i] = 1;
    end
    mBr = 0; mMis = 0;
  endtask

  task automatic mTrain(input vec_t v);
    int s;
    s = slotOf(v.pce);
    if (mMisp(v)) mMis++;
    if (!v.upd) return;
    mBr++;
    if (mHit(v.pce)) begin
      if (v.jmp) begin
        mCtr[s] = 3; mTgt[s] = v.tgt;
      end else if (v.tkn) begin
        mCtr[s] = (mCtr[s] < 3) ? mCtr[s] + 1 : 3; mTgt[s] = v.tgt;
      end else begin
        mCtr[s] = (mCtr[s] > 0) ? mCtr[s] - 1 : 0;
      end
    end else if (v.tkn) begin
      mValid[s] = 1; mTag[s] = v.pce / 64; mTgt[s] = v.tgt; mCtr[s] = v.jmp ? 3 : 2;
    end
  endtask

  function automatic logic [31:0] randPc();
    return 32'h0000_1000 + ($urandom_range(0, 63) * 4);
  endfunction

  initial begin
    vec_t v;
    rst = 1'b1;
    drive(mk(32'h100, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("reset PredTakenF", PredTakenF, 0);
    chk("reset PredTargetF", PredTargetF, 32'h104);
    chk("reset BranchCnt", BranchCnt, 0);
    chk("reset MispredCnt", MispredCnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    //       pcf      upd jmp pce          tkn tgt     ptk ptg     eTk eTg     eMis eRec
    vecs.push_back(mk(32'h100, 0, 0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h80,  0, 32'h104, 0, 32'h104, 1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h80,  1, 32'h80,  1, 32'h80,  1, 32'h104));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h80,  0, 32'h80,  0, 32'h80,  0, 32'h104));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 0, 32'h80,  0, 32'h80,  0, 32'h80,  0, 32'h104));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h80,  0, 32'h80,  0, 32'h80,  1, 32'h80));
    vecs.push_back(mk(32'h100, 1, 0, 32'h100, 1, 32'h80,  0, 32'h80,  0, 32'h80,  1, 32'h80));
    vecs.push_back(mk(32'h140, 0, 0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h104));
    vecs.push_back(mk(32'h100, 0, 0, 32'h100, 0, 32'h0,   0, 32'h0,   1, 32'h80,  0, 32'h104));
    vecs.push_back(mk(32'h140, 1, 0, 32'h140, 1, 32'h40,  0, 32'h144, 0, 32'h144, 1, 32'h40));
    vecs.push_back(mk(32'h100, 0, 0, 32'h100, 0, 32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h104));
    vecs.push_back(mk(32'h140, 0, 0, 32'h140, 0, 32'h0,   0, 32'h0,   1, 32'h40,  0, 32'h144));
    vecs.push_back(mk(32'h200, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 32'h204, 1, 32'h300));
    vecs.push_back(mk(32'h200, 1, 1, 32'h200, 1, 32'h304, 1, 32'h300, 1, 32'h300, 1, 32'h304));
    vecs.push_back(mk(32'h200, 0, 0, 32'h200, 0, 32'h0,   0, 32'h0,   1, 32'h304, 0, 32'h204));
    vecs.push_back(mk(32'h208, 1, 1, 32'h200, 1, 32'h304, 1, 32'h304, 0, 32'h20C, 0, 32'h304));
    vecs.push_back(mk(32'h200, 0, 0, 32'h500, 1, 32'h600, 0, 32'h0,   1, 32'h304, 0, 32'h600));
    vecs.push_back(mk(32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d PredTakenF", i), PredTakenF, vecs[i].eTk);
      chk($sformatf("vec%0d PredTargetF", i), PredTargetF, vecs[i].eTg);
      chk($sformatf("vec%0d MispredictE", i), MispredictE, vecs[i].eMis);
      chk($sformatf("vec%0d RecoverPCE", i), RecoverPCE, vecs[i].eRec);
      @(posedge clk); #1;
    end
    chk("table BranchCnt", BranchCnt, 10);
    chk("table MispredCnt", MispredCnt, 7);

    // Reset asserted mid-cycle while an update is being presented.
    drive(mk(32'h200, 1, 0, 32'h400, 1, 32'h44, 0, 32'h404, 0, 0, 0, 0));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst PredTakenF", PredTakenF, 0);
    chk("midrst PredTargetF", PredTargetF, 32'h204);
    chk("midrst BranchCnt", BranchCnt, 0);
    chk("midrst MispredCnt", MispredCnt, 0);
    chk("midrst RecoverPCE", RecoverPCE, 32'h44);
    @(posedge clk); #1;
    rst = 1'b0;
    UpdateE = 1'b0;
    PCF = 32'h400;
    #1;
    chk("postrst 0x400 taken", PredTakenF, 0);
    chk("postrst 0x400 target", PredTargetF, 32'h404);
    @(posedge clk); #1;
    chk("postrst BranchCnt", BranchCnt, 0);
    chk("postrst MispredCnt", MispredCnt, 0);

    mReset();
    for (int n = 0; n < 600; n++) begin
      int s;
      v.pce = randPc();
      v.pcf = ($urandom_range(0, 3) == 0) ? v.pce : randPc();
      v.upd = ($urandom_range(0, 3) != 0);
      v.jmp = ($urandom_range(0, 3) == 0);
      v.tkn = v.jmp ? 1'b1 : 1'($urandom_range(0, 1));
      v.tgt = 32'h0000_2000 + ($urandom_range(0, 7) * 4);
      s = slotOf(v.pce);
      if ($urandom_range(0, 2) != 0) begin
        v.ptk = mHit(v.pce) && (mCtr[s] >= 2);
        v.ptg = mHit(v.pce) ? mTgt[s] : v.pce + 32'd4;
      end else begin
        v.ptk = 1'($urandom_range(0, 1));
        v.ptg = 32'h0000_2000 + ($urandom_range(0, 7) * 4);
      end
      drive(v);
      #1;
      s = slotOf(v.pcf);
      chk("rnd PredTakenF", PredTakenF, mHit(v.pcf) && (mCtr[s] >= 2));
      chk("rnd PredTargetF", PredTargetF, mHit(v.pcf) ? mTgt[s] : v.pcf + 32'd4);
      chk("rnd MispredictE", MispredictE, mMisp(v));
      chk("rnd RecoverPCE", RecoverPCE, v.tkn ? v.tgt : v.pce + 32'd4);
      @(posedge clk);
      mTrain(v);
      #1;
      chk("rnd BranchCnt", BranchCnt, mBr);
      chk("rnd MispredCnt", MispredCnt, mMis);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
